mem_access_unit: RTL and testbench

Memory-access stage of the scalar CPU pipeline. Sits directly downstream of the execute-stage ALU and consumes its 32-bit result as either an effective address (loads/stores) or a pass-through value (all other ops). It drives a single-outstanding req/ack data-memory port with byte lanes, aligns and extends load data, and presents one write-back beat per accepted operation. Misaligned and unsupported accesses are reported instead of issued.

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 12 +
 rtl/mem_access_unit_align.sv | 34 +++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 codes, FSM states and byte-enable patterns shared by
// the memory-access stage and its alignment helper.
package mem_access_unit_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;
    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: single-outstanding req/ack data-memory port with byte lanes.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_align.sv
// mem_align: combinational byte-lane steering, load extraction and legality/alignment checks.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        legal,
    output logic        aligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;
    always_comb begin
        legal = is_store ? (funct3 inside {F3_SB, F3_SH, F3_SW})
                         : (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        aligned = funct3[1:0] == 2'b00 || (funct3[1:0] == 2'b01 && !addr[0]) ||
                  (funct3[1:0] == 2'b10 && addr == 2'b00);
        be = funct3[1:0] == 2'b00 ? BE_B << addr :
             funct3[1:0] == 2'b01 ? (addr[1] ? BE_HHI : BE_HLO) : BE_W;
        wdata_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        sext = !funct3[2];
        rdata_ext = funct3[1:0] == 2'b00 ? {{24{sext & byte_sel[7]}}, byte_sel} :
                    funct3[1:0] == 2'b01 ? {{16{sext & half_sel[15]}}, half_sel} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory-access stage; issues aligned dmem requests,
// extends load data and produces one registered write-back beat per accepted op.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int N    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [N-1:0]    ex_result,
    input  logic [N-1:0]    ex_wdata,
    input  logic [RD_W-1:0] ex_rd,
    mem_access_unit_if.master dmem,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [RD_W-1:0] wb_rd,
    output logic [N-1:0]    wb_data,
    output logic            exc_misaligned,
    output logic            exc_illegal,
    output logic [N-1:0]    exc_addr
);
    state_t      state;
    logic        is_ld;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic        idle;
    logic        al_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_a;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_legal;
    logic        al_aligned;
    // One aligner serves both phases: ex_* inputs while idle, captured op during REQ.
    always_comb begin
        idle     = state == ST_IDLE;
        ex_ready = idle;
        al_store = idle ? ex_is_store & ~ex_is_load : ~is_ld;
        al_f3    = idle ? ex_funct3 : f3_q;
        al_a     = idle ? ex_result[1:0] : a_q;
    end
    mem_align u_align (
        .is_store  (al_store),
        .funct3    (al_f3),
        .addr      (al_a),
        .wdata     (ex_wdata),
        .rdata     (dmem.rdata),
        .be        (al_be),
        .wdata_lane(al_wdata),
        .rdata_ext (al_rdata),
        .legal     (al_legal),
        .aligned   (al_aligned)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            is_ld          <= 1'b0;
            f3_q           <= '0;
            a_q            <= '0;
            dmem.req       <= 1'b0;
            dmem.we        <= 1'b0;
            dmem.addr      <= '0;
            dmem.be        <= '0;
            dmem.wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_en          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
            exc_illegal    <= 1'b0;
            exc_addr       <= '0;
        end else begin
            wb_valid       <= 1'b0;
            wb_en          <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_illegal    <= 1'b0;
            if (idle) begin
                if (ex_valid) begin
                    wb_rd <= ex_rd;
                    is_ld <= ex_is_load;
                    f3_q  <= ex_funct3;
                    a_q   <= ex_result[1:0];
                    if (!(ex_is_load || ex_is_store)) begin
                        wb_valid <= 1'b1;
                        wb_en    <= ex_rd != '0;
                        wb_data  <= ex_result;
                    end else if (!al_legal || !al_aligned) begin
                        wb_valid       <= 1'b1;
                        exc_illegal    <= !al_legal;
                        exc_misaligned <= al_legal;
                        exc_addr       <= ex_result;
                    end else begin
                        state      <= ST_REQ;
                        dmem.req   <= 1'b1;
                        dmem.we    <= !ex_is_load;
                        dmem.addr  <= {ex_result[31:2], 2'b00};
                        dmem.be    <= al_be;
                        dmem.wdata <= al_wdata;
                    end
                end
            end else if (dmem.ack) begin
                state    <= ST_IDLE;
                dmem.req <= 1'b0;
                wb_valid <= 1'b1;
                wb_en    <= is_ld && wb_rd != '0;
                if (is_ld) wb_data <= al_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed steps with a scoreboard of expected write-back beats.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_ready, wb_valid, wb_en, exc_misaligned, exc_illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    int          total = 0;
    int          bad = 0;
    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        ill;
        logic [31:0] addr;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    mem_access_unit_if dif();

    mem_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_funct3     (ex_funct3),
        .ex_result     (ex_result),
        .ex_wdata      (ex_wdata),
        .ex_rd         (ex_rd),
        .dmem          (dif),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .exc_misaligned(exc_misaligned),
        .exc_illegal   (exc_illegal),
        .exc_addr      (exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write-back beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        beat_t e;
        if (wb_valid) begin
            if (sb.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("wb_en", 32'(wb_en), 32'(e.en));
                chk("exc_misaligned", 32'(exc_misaligned), 32'(e.mis));
                chk("exc_illegal", 32'(exc_illegal), 32'(e.ill));
                if (e.en) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
                if (e.mis || e.ill) chk("exc_addr", exc_addr, e.addr);
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_result   = res;
        ex_wdata    = wd;
        ex_rd       = rd;
    endtask

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        sb.push_back('{en: rd != 0, rd: rd, data: res, mis: 1'b0, ill: 1'b0, addr: 32'd0});
        drive(1'b0, 1'b0, 3'b000, res, 32'd0, rd);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_no_req", 32'(dif.req), 32'd0);
    endtask

    task automatic exc(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic mis, input logic ill);
        sb.push_back('{en: 1'b0, rd: 5'd4, data: 32'd0, mis: mis, ill: ill, addr: a});
        drive(ld, st, f3, a, 32'h1111_2222, 5'd4);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("exc_wb_valid", 32'(wb_valid), 32'd1);
        chk("exc_no_req", 32'(dif.req), 32'd0);
    endtask

    task automatic mem(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input int k, input logic [31:0] rdv, input logic [31:0] exp_data,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
        sb.push_back('{en: ld && rd != 0, rd: rd, data: exp_data, mis: 1'b0, ill: 1'b0, addr: 32'd0});
        drive(ld, st, f3, a, wd, rd);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 1; i <= k; i++) begin
            chk("req", 32'(dif.req), 32'd1);
            chk("ex_ready_req", 32'(ex_ready), 32'd0);
            chk("addr", dif.addr, {a[31:2], 2'b00});
            chk("we", 32'(dif.we), 32'(st & ~ld));
            if (st && !ld) begin
                chk("be", 32'(dif.be), 32'(exp_be));
                chk("wdata", dif.wdata, exp_wd);
            end
            if (i == k) begin
                dif.ack   = 1'b1;
                dif.rdata = rdv;
            end
            @(negedge clk);
        end
        dif.ack   = 1'b0;
        dif.rdata = '0;
        chk("wb_valid_mem", 32'(wb_valid), 32'd1);
        chk("ex_ready_wb", 32'(ex_ready), 32'd1);
        chk("req_drop", 32'(dif.req), 32'd0);
    endtask

    initial begin
        dif.ack   = 1'b0;
        dif.rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req", 32'(dif.req), 32'd0);
        chk("rst_be", 32'(dif.be), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        alu(32'h0000_1234, 5'd5);
        alu(32'h0000_0042, 5'd0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{en: 1'b1, rd: 5'(i + 1), data: 32'h100 + 32'(i), mis: 1'b0, ill: 1'b0, addr: 32'd0});
            drive(1'b0, 1'b0, 3'b000, 32'h100 + 32'(i), 32'd0, 5'(i + 1));
            @(negedge clk);
            chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
            chk("b2b_no_req", 32'(dif.req), 32'd0);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        mem(1'b1, 1'b0, F3_LB,  32'h0000_1003, 32'd0, 5'd7, 1, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'd0, 32'd0);
        mem(1'b1, 1'b0, F3_LBU, 32'h0000_1003, 32'd0, 5'd7, 1, 32'h80FF_FF7F, 32'h0000_0080, 4'd0, 32'd0);
        mem(1'b0, 1'b1, F3_SH,  32'h0000_2002, 32'hDEAD_BEEF, 5'd8, 4, 32'd0, 32'd0, 4'b1100, 32'hBEEF_BEEF);
        mem(1'b1, 1'b0, F3_LH,  32'h0000_1002, 32'd0, 5'd10, 1, 32'h8001_1234, 32'hFFFF_8001, 4'd0, 32'd0);
        mem(1'b1, 1'b0, F3_LHU, 32'h0000_1000, 32'd0, 5'd11, 3, 32'h8001_F234, 32'h0000_F234, 4'd0, 32'd0);
        mem(1'b1, 1'b0, F3_LW,  32'h0000_3000, 32'd0, 5'd9, 2, 32'h1234_5678, 32'h1234_5678, 4'd0, 32'd0);
        mem(1'b0, 1'b1, F3_SB,  32'h0000_5001, 32'h0000_00AB, 5'd1, 1, 32'd0, 32'd0, 4'b0010, 32'hABAB_ABAB);
        mem(1'b0, 1'b1, F3_SW,  32'h0000_6000, 32'hCAFE_F00D, 5'd1, 2, 32'd0, 32'd0, 4'b1111, 32'hCAFE_F00D);
        mem(1'b1, 1'b0, F3_LB,  32'h0000_7000, 32'd0, 5'd0, 1, 32'h0000_0005, 32'd0, 4'd0, 32'd0);
        mem(1'b1, 1'b1, F3_LBU, 32'h0000_1001, 32'd0, 5'd12, 1, 32'h0000_AB00, 32'h0000_00AB, 4'd0, 32'd0);
        exc(1'b1, 1'b0, F3_LW, 32'h0000_3001, 1'b1, 1'b0);
        exc(1'b1, 1'b0, 3'b011, 32'h0000_3000, 1'b0, 1'b1);
        exc(1'b0, 1'b1, 3'b100, 32'h0000_3003, 1'b0, 1'b1);
        exc(1'b1, 1'b0, F3_LH, 32'h0000_1001, 1'b1, 1'b0);
        exc(1'b0, 1'b1, F3_SW, 32'h0000_2002, 1'b1, 1'b0);
        @(negedge clk);
        dif.ack = 1'b1;
        @(negedge clk);
        dif.ack = 1'b0;
        chk("spur_wb_valid", 32'(wb_valid), 32'd0);
        chk("spur_req", 32'(dif.req), 32'd0);
        chk("spur_ready", 32'(ex_ready), 32'd1);
        drive(1'b1, 1'b0, F3_LW, 32'h0000_4000, 32'd0, 5'd3);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("pre_rst_req", 32'(dif.req), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_req", 32'(dif.req), 32'd0);
        chk("async_rst_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk("rst_no_wb", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        alu(32'h0000_ABCD, 5'd6);
        mem(1'b1, 1'b0, F3_LW, 32'h0000_4000, 32'd0, 5'd3, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'd0, 32'd0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
